// File: rtl/rbt_meta_pkg.sv
// ============================================================================
//  Module      : rbt_meta_pkg
//  Description : Shared packet-metadata layout for the header-parser layers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rbt_meta_pkg;

  localparam int PROPERTY_NO    = 246;
  localparam int PROPERTY_WIDTH = 8;

  // Bit positions inside the packet-property tag field.
  localparam int DAT    = 0;
  localparam int SEADP  = 1;
  localparam int SEAUP  = 2;
  localparam int SEASP  = 3;
  localparam int XTRANS = 6;
  localparam int RFLAG  = 7;

  localparam int RPN_NO      = 72;
  localparam int RPN_WIDTH   = 32;
  localparam int RSIP_OFFSET = 48;
  localparam int RSIP_WIDTH  = 128;
  localparam int ERR_BIT_NO  = 254;

  localparam logic [PROPERTY_WIDTH-1:0] TRANSPORT_REQ_MASK =
    PROPERTY_WIDTH'((1 << DAT) | (1 << XTRANS) | (1 << RFLAG));

  typedef enum logic [1:0] {
    CLS_PASS    = 2'd0,
    CLS_EXTRACT = 2'd1,
    CLS_SHORT   = 2'd2
  } cls_e;

  function automatic logic tags_match(input logic [PROPERTY_WIDTH-1:0] prop,
                                      input logic [PROPERTY_WIDTH-1:0] mask);
    return (prop & mask) == mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rbt_skid_buffer.sv
// ============================================================================
//  Module      : rbt_skid_buffer
//  Description : Two-entry valid/ready stage with registered input ready.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rbt_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             out_valid_q;
  logic             skid_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [WIDTH-1:0] skid_data_q;
  logic             accept;
  logic             load_out;

  assign accept   = in_valid_i & ~skid_valid_q;
  assign load_out = ~out_valid_q | out_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_data_q   <= '0;
      skid_data_q  <= '0;
    end else if (load_out) begin
      // The skid entry is always older than anything on the input.
      if (skid_valid_q) begin
        out_valid_q  <= 1'b1;
        out_data_q   <= skid_data_q;
        skid_valid_q <= 1'b0;
      end else begin
        out_valid_q <= accept;
        if (accept) out_data_q <= in_data_i;
      end
    end else if (accept) begin
      skid_valid_q <= 1'b1;
      skid_data_q  <= in_data_i;
    end
  end

  assign in_ready_o  = ~skid_valid_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

`default_nettype wire

// File: rtl/rbt_s_transport_field_extractor.sv
// ============================================================================
//  Module      : rbt_s_transport_field_extractor
//  Description : Copies a transport-header field into metadata for tagged
//                packets, flags short headers, keeps saturating statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rbt_s_transport_field_extractor
  import rbt_meta_pkg::*;
#(
  parameter int                          HEADER_WIDTH       = 2048,
  parameter int                          PKT_METADATA_WIDTH = 272,
  parameter int                          PROPERTY_NO        = rbt_meta_pkg::PROPERTY_NO,
  parameter int                          PROPERTY_WIDTH     = rbt_meta_pkg::PROPERTY_WIDTH,
  parameter logic [PROPERTY_WIDTH-1:0]   REQ_TAG_MASK       = TRANSPORT_REQ_MASK,
  parameter int                          FIELD_OFFSET       = RSIP_OFFSET + RSIP_WIDTH,
  parameter int                          FIELD_WIDTH        = RPN_WIDTH,
  parameter int                          FIELD_NO           = RPN_NO,
  parameter int                          ERR_BIT_NO         = rbt_meta_pkg::ERR_BIT_NO,
  parameter int                          CNT_WIDTH          = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_proto_hdr_valid,
  output logic                          in_proto_hdr_ready,
  input  logic [15:0]                   in_proto_hdr_length,
  input  logic [HEADER_WIDTH-1:0]       in_proto_hdr_data,
  input  logic [PKT_METADATA_WIDTH-1:0] in_proto_hdr_pkt_metadata,
  output logic                          out_proto_hdr_valid,
  input  logic                          out_proto_hdr_ready,
  output logic [15:0]                   out_proto_hdr_length,
  output logic [HEADER_WIDTH-1:0]       out_proto_hdr_data,
  output logic [PKT_METADATA_WIDTH-1:0] out_proto_hdr_pkt_metadata,
  input  logic                          stat_clear,
  output logic [CNT_WIDTH-1:0]          stat_extract_count,
  output logic [CNT_WIDTH-1:0]          stat_short_count
);

  localparam int FIELD_END = FIELD_OFFSET + FIELD_WIDTH;
  localparam int FIELD_MSB = HEADER_WIDTH - 1 - FIELD_OFFSET;
  localparam int BEAT_W    = 16 + HEADER_WIDTH + PKT_METADATA_WIDTH;

  if (HEADER_WIDTH % 8 != 0) begin : g_bad_header_width
    $error("HEADER_WIDTH must be a multiple of 8");
  end
  if (FIELD_END > HEADER_WIDTH) begin : g_bad_field_range
    $error("extracted field lies beyond the header bus");
  end

  logic [PROPERTY_WIDTH-1:0]     prop;
  logic                          match;
  logic                          fits;
  cls_e                          cls;
  logic [PKT_METADATA_WIDTH-1:0] meta_upd;
  logic                          accept;
  logic [CNT_WIDTH-1:0]          extract_cnt_q, extract_cnt_d;
  logic [CNT_WIDTH-1:0]          short_cnt_q, short_cnt_d;

  assign prop  = in_proto_hdr_pkt_metadata[PROPERTY_NO +: PROPERTY_WIDTH];
  assign match = tags_match(prop, REQ_TAG_MASK);
  // Byte length scaled to bits at 19 bits so 16'hFFFF cannot wrap.
  assign fits  = {in_proto_hdr_length, 3'b000} >= 19'(FIELD_END);

  always_comb begin
    meta_upd = in_proto_hdr_pkt_metadata;
    cls      = CLS_PASS;
    if (match) begin
      if (fits) begin
        meta_upd[FIELD_NO +: FIELD_WIDTH] = in_proto_hdr_data[FIELD_MSB -: FIELD_WIDTH];
        meta_upd[ERR_BIT_NO]              = 1'b0;
        cls                               = CLS_EXTRACT;
      end else begin
        meta_upd[ERR_BIT_NO] = 1'b1;
        cls                  = CLS_SHORT;
      end
    end
  end

  assign accept = in_proto_hdr_valid & in_proto_hdr_ready;

  always_comb begin
    extract_cnt_d = extract_cnt_q;
    short_cnt_d   = short_cnt_q;
    if (stat_clear) begin
      extract_cnt_d = '0;
      short_cnt_d   = '0;
    end else if (accept) begin
      if (cls == CLS_EXTRACT && extract_cnt_q != '1)
        extract_cnt_d = extract_cnt_q + CNT_WIDTH'(1);
      if (cls == CLS_SHORT && short_cnt_q != '1)
        short_cnt_d = short_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      extract_cnt_q <= '0;
      short_cnt_q   <= '0;
    end else begin
      extract_cnt_q <= extract_cnt_d;
      short_cnt_q   <= short_cnt_d;
    end
  end

  rbt_skid_buffer #(
    .WIDTH (BEAT_W)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_proto_hdr_valid),
    .in_ready_o  (in_proto_hdr_ready),
    .in_data_i   ({in_proto_hdr_length, in_proto_hdr_data, meta_upd}),
    .out_valid_o (out_proto_hdr_valid),
    .out_ready_i (out_proto_hdr_ready),
    .out_data_o  ({out_proto_hdr_length, out_proto_hdr_data, out_proto_hdr_pkt_metadata})
  );

  assign stat_extract_count = extract_cnt_q;
  assign stat_short_count   = short_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_rbt_s_transport_field_extractor.sv
// ============================================================================
//  Module      : tb_rbt_s_transport_field_extractor
//  Description : Scoreboard bench for the transport field extractor.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rbt_s_transport_field_extractor;

  localparam int HW = 2048;
  localparam int MW = 272;
  localparam int CW = 4;
  localparam int CMAX = 15;

  typedef struct {
    logic [15:0]   len;
    logic [HW-1:0] data;
    logic [MW-1:0] meta;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [15:0]   in_len = '0;
  logic [HW-1:0] in_data = '0;
  logic [MW-1:0] in_meta = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [15:0]   out_len;
  logic [HW-1:0] out_data;
  logic [MW-1:0] out_meta;
  logic          stat_clear = 1'b0;
  logic [CW-1:0] ext_cnt;
  logic [CW-1:0] short_cnt;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    mode = 0;      // 0: random out_ready, 1: always ready, 2: never ready
  int    stalls = 0;
  int    last_out_edge = 0;
  int    ext_m = 0;
  int    short_m = 0;
  beat_t sb[$];

  rbt_s_transport_field_extractor #(
    .CNT_WIDTH (CW)
  ) dut (
    .clk                        (clk),
    .rst                        (rst),
    .in_proto_hdr_valid         (in_valid),
    .in_proto_hdr_ready         (in_ready),
    .in_proto_hdr_length        (in_len),
    .in_proto_hdr_data          (in_data),
    .in_proto_hdr_pkt_metadata  (in_meta),
    .out_proto_hdr_valid        (out_valid),
    .out_proto_hdr_ready        (out_ready),
    .out_proto_hdr_length       (out_len),
    .out_proto_hdr_data         (out_data),
    .out_proto_hdr_pkt_metadata (out_meta),
    .stat_clear                 (stat_clear),
    .stat_extract_count         (ext_cnt),
    .stat_short_count           (short_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: RPN sits right after the 48-bit prefix and 128-bit RSIP.
  function automatic beat_t model(input beat_t b, output int kind);
    beat_t r;
    int    prop;
    int    hdr_bits;
    r        = b;
    kind     = 0;
    prop     = int'((b.meta >> 246) & 272'hFF);
    hdr_bits = int'(b.len) * 8;
    if ((prop & 'hC1) == 'hC1) begin
      if (hdr_bits >= 48 + 128 + 32) begin
        r.meta[72 +: 32] = 32'(b.data >> (HW - 208));
        r.meta[254]      = 1'b0;
        kind             = 1;
      end else begin
        r.meta[254] = 1'b1;
        kind        = 2;
      end
    end
    return r;
  endfunction

  function automatic logic [HW-1:0] rnd_data();
    logic [HW-1:0] v;
    for (int i = 0; i < HW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [MW-1:0] rnd_meta();
    logic [287:0] v;
    for (int i = 0; i < 9; i++) v[i*32 +: 32] = $urandom();
    return v[MW-1:0];
  endfunction

  function automatic int first_diff(input logic [HW-1:0] a, input logic [HW-1:0] b);
    for (int i = 0; i < HW / 32; i++)
      if (a[i*32 +: 32] !== b[i*32 +: 32]) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [15:0] len, input logic [HW-1:0] data,
                      input logic [MW-1:0] meta, input bit clr);
    beat_t b;
    int    kind;
    bit    r;
    bit    ok;
    int    waits;
    b.len = len; b.data = data; b.meta = meta;
    in_valid = 1'b1; in_len = len; in_data = data; in_meta = meta; stat_clear = clr;
    ok = 1'b0;
    waits = 0;
    while (!ok && waits < 1000) begin
      r = in_ready;
      @(posedge clk);
      if (clr) begin ext_m = 0; short_m = 0; end
      if (r) begin
        ok = 1'b1;
        sb.push_back(model(b, kind));
        if (!clr && kind == 1 && ext_m < CMAX) ext_m++;
        if (!clr && kind == 2 && short_m < CMAX) short_m++;
      end else begin
        waits++;
      end
      @(negedge clk);
    end
    stalls += waits;
    in_valid = 1'b0;
    stat_clear = 1'b0;
    if (!ok) chk("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 64'(sb.size()), 64'(0));
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_extract_count"}, 64'(ext_cnt), 64'(ext_m));
    chk({tag, "_short_count"}, 64'(short_cnt), 64'(short_m));
  endtask

  function automatic logic [MW-1:0] with_tags(input logic [MW-1:0] m, input logic [7:0] t);
    logic [MW-1:0] r = m;
    r[246 +: 8] = t;
    return r;
  endfunction

  // Monitor: choose out_ready for the coming edge, then score the transfer it makes.
  bit            prev_stall = 1'b0;
  logic [15:0]   p_len;
  logic [HW-1:0] p_data;
  logic [MW-1:0] p_meta;
  always @(negedge clk) begin
    beat_t e;
    int    d;
    case (mode)
      0:       out_ready = 1'($urandom_range(0, 1));
      1:       out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!out_valid || out_len !== p_len || out_data !== p_data || out_meta !== p_meta) begin
          errors++;
          $display("FAIL hold_stable: valid=%b len=%h was %h meta=%h was %h", out_valid, out_len, p_len, out_meta, p_meta);
        end
      end
      if (!in_ready) begin
        checks++;
        if (!out_valid) begin
          errors++;
          $display("FAIL ready_low_while_empty: in_ready=%b out_valid=%b required out_valid=1", in_ready, out_valid);
        end
      end
      if (out_valid && out_ready) begin
        last_out_edge = cyc + 1;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: len=%h meta=%h with empty scoreboard", out_len, out_meta);
        end else begin
          e = sb.pop_front();
          chk("out_length", 64'(out_len), 64'(e.len));
          checks++;
          if (out_meta !== e.meta) begin
            errors++;
            $display("FAIL out_metadata: got %h expected %h", out_meta, e.meta);
          end
          checks++;
          d = first_diff(out_data, e.data);
          if (d >= 0) begin
            errors++;
            $display("FAIL out_data word %0d: got %h expected %h", d, out_data[d*32 +: 32], e.data[d*32 +: 32]);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      p_len = out_len; p_data = out_data; p_meta = out_meta;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [HW-1:0] d;
    logic [MW-1:0] m;
    logic [15:0]   l;
    int            t0;
    int            st0;

    repeat (3) @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    chk("reset_out_zero", 64'(out_len == '0 && out_data == '0 && out_meta == '0), 64'(1));
    chk_counters("reset");
    rst = 1'b0;
    mode = 1;
    @(negedge clk);

    // Directed: extract, tag mismatch, short header, length boundaries.
    d = '0;
    d[1871:1840] = 32'hDEADBEEF;
    m = with_tags(rnd_meta(), 8'hC1);
    send(16'd64, d, m, 1'b0);
    drain();
    chk("t1_extract_count", 64'(ext_cnt), 64'(1));
    chk("t1_short_count", 64'(short_cnt), 64'(0));

    send(16'd64, d, with_tags(m, 8'h41), 1'b0);
    drain();
    chk_counters("t2");

    send(16'd25, rnd_data(), with_tags(rnd_meta(), 8'hC1), 1'b0);
    drain();
    chk("t3_short_count", 64'(short_cnt), 64'(1));

    send(16'd0, rnd_data(), with_tags(rnd_meta(), 8'hFF), 1'b0);
    send(16'd26, rnd_data(), with_tags(rnd_meta(), 8'hC1), 1'b0);
    send(16'hFFFF, rnd_data(), with_tags(rnd_meta(), 8'hC3), 1'b0);
    drain();
    chk_counters("boundary");

    // Random traffic with random back-pressure.
    mode = 0;
    @(negedge clk);
    for (int i = 0; i < 100; i++) begin
      m = rnd_meta();
      case ($urandom_range(0, 3))
        0, 1: m[246 +: 8] = m[246 +: 8] | 8'hC1;
        2:    m[253] = 1'b0;
        default: ;
      endcase
      case ($urandom_range(0, 4))
        0:       l = 16'd0;
        1:       l = 16'd25;
        2:       l = 16'd26;
        default: l = 16'($urandom_range(0, 65535));
      endcase
      send(l, rnd_data(), m, 1'b0);
    end
    drain();
    chk_counters("random");

    // Throughput: 100 beats back-to-back, always ready.
    mode = 1;
    @(negedge clk);
    st0 = stalls;
    t0 = cyc;
    for (int i = 0; i < 100; i++)
      send(16'($urandom_range(26, 255)), rnd_data(), with_tags(rnd_meta(), 8'($urandom)), 1'b0);
    drain();
    chk("throughput_stalls", 64'(stalls - st0), 64'(0));
    chk("throughput_span", 64'(last_out_edge - t0), 64'(101));

    // Counter clear, saturation, clear racing an increment.
    stat_clear = 1'b1;
    @(posedge clk);
    ext_m = 0; short_m = 0;
    @(negedge clk);
    stat_clear = 1'b0;
    chk_counters("clear");
    for (int i = 0; i < 20; i++)
      send(16'd64, rnd_data(), with_tags(rnd_meta(), 8'hC1), 1'b0);
    drain();
    chk("sat_extract_count", 64'(ext_cnt), 64'(CMAX));
    send(16'd64, rnd_data(), with_tags(rnd_meta(), 8'hC1), 1'b1);
    drain();
    chk("clear_wins_extract", 64'(ext_cnt), 64'(0));
    chk_counters("clear_wins");

    // Reset with output stalled and skid full.
    mode = 2;
    @(negedge clk);
    send(16'd64, rnd_data(), with_tags(rnd_meta(), 8'hC1), 1'b0);
    send(16'd10, rnd_data(), with_tags(rnd_meta(), 8'hC1), 1'b0);
    chk("stall_in_ready", 64'(in_ready), 64'(0));
    chk("stall_out_valid", 64'(out_valid), 64'(1));
    rst = 1'b1;
    @(posedge clk);
    sb.delete();
    ext_m = 0; short_m = 0;
    @(negedge clk);
    chk("rst_mid_out_valid", 64'(out_valid), 64'(0));
    chk("rst_mid_in_ready", 64'(in_ready), 64'(1));
    chk_counters("rst_mid");
    rst = 1'b0;
    mode = 1;
    @(negedge clk);
    send(16'd40, rnd_data(), with_tags(rnd_meta(), 8'hC1), 1'b0);
    drain();
    chk_counters("post_reset");

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
